// File: rtl/multi_solver_pingpong.sv
// Collects per-lane solver result streams into private ping-pong banks and serves
// a linear pixel read port (pixel p -> lane p mod N, slot p div N), 1-cycle read latency.
module multi_solver_pingpong #(
  parameter int  LANE_W      = 2,
  parameter int  DATA_W      = 8,
  parameter int  ADDR_W      = 10,
  localparam int NUM_SOLVERS = 1 << LANE_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  output logic                          sol_start,
  input  logic [NUM_SOLVERS-1:0]        sol_valid,
  input  logic [NUM_SOLVERS*DATA_W-1:0] sol_data,
  input  logic [NUM_SOLVERS-1:0]        sol_done,
  output logic [NUM_SOLVERS-1:0]        sol_continue,
  input  logic                          rd_en,
  input  logic [ADDR_W+LANE_W-1:0]      rd_pixel,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          busy,
  output logic                          done,
  output logic                          frame_ready,
  output logic [NUM_SOLVERS-1:0]        overflow
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [ADDR_W:0]         ptr_q [NUM_SOLVERS];
  logic [ADDR_W:0]         ptr_d [NUM_SOLVERS];
  logic [NUM_SOLVERS-1:0]  overflow_q, overflow_d;
  logic [NUM_SOLVERS-1:0]  wr_en;
  logic                    done_q, done_d;
  logic                    frame_ready_q, frame_ready_d;
  logic                    sol_start_q, sol_start_d;
  logic                    rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;

  logic [DATA_W-1:0]       lane_rd [NUM_SOLVERS];
  logic [LANE_W-1:0]       rd_lane;
  logic [ADDR_W-1:0]       rd_slot;

  assign rd_lane = rd_pixel[LANE_W-1:0];
  assign rd_slot = rd_pixel[ADDR_W+LANE_W-1:LANE_W];

  // Done lanes are never acknowledged, so a finished solver cannot push stray results.
  always_comb begin
    sol_continue = '0;
    if (state_q == RUN) begin
      sol_continue = sol_valid & ~sol_done;
    end
  end

  always_comb begin
    state_d       = state_q;
    rd_bank_d     = rd_bank_q;
    ptr_d         = ptr_q;
    overflow_d    = overflow_q;
    wr_en         = '0;
    done_d        = 1'b0;
    frame_ready_d = frame_ready_q;
    sol_start_d   = 1'b0;
    rd_valid_d    = rd_en;
    rd_data_d     = rd_en ? lane_rd[rd_lane] : rd_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          sol_start_d = 1'b1;
          overflow_d  = '0;
          for (int i = 0; i < NUM_SOLVERS; i++) begin
            ptr_d[i] = '0;
          end
        end
      end
      RUN: begin
        // A full lane still acknowledges so the solver never stalls; the result is dropped.
        for (int i = 0; i < NUM_SOLVERS; i++) begin
          if (sol_continue[i]) begin
            if (ptr_q[i] == PTR_FULL) begin
              overflow_d[i] = 1'b1;
            end else begin
              wr_en[i] = 1'b1;
              ptr_d[i] = ptr_q[i] + PTR_ONE;
            end
          end
        end
        if (&sol_done) begin
          state_d       = IDLE;
          rd_bank_d     = ~rd_bank_q;
          done_d        = 1'b1;
          frame_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      rd_bank_q     <= 1'b1;
      ptr_q         <= '{default: '0};
      overflow_q    <= '0;
      done_q        <= 1'b0;
      frame_ready_q <= 1'b0;
      sol_start_q   <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      rd_bank_q     <= rd_bank_d;
      ptr_q         <= ptr_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
      frame_ready_q <= frame_ready_d;
      sol_start_q   <= sol_start_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  // Per-lane storage: address = {bank, slot}; the write side always targets the non-read bank.
  for (genvar g = 0; g < NUM_SOLVERS; g++) begin : g_lane
    logic [DATA_W-1:0] ram [2*DEPTH];

    always_ff @(posedge clock) begin
      if (wr_en[g] && !reset) begin
        ram[{~rd_bank_q, ptr_q[g][ADDR_W-1:0]}] <= sol_data[g*DATA_W +: DATA_W];
      end
    end

    assign lane_rd[g] = ram[{rd_bank_q, rd_slot}];
  end

  assign sol_start   = sol_start_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign frame_ready = frame_ready_q;
  assign overflow    = overflow_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;

endmodule

// File: tb/tb_multi_solver_pingpong.sv
// Randomized bench for multi_solver_pingpong with a frame/pixel-level reference model.
module tb_multi_solver_pingpong;

  localparam int LANE_W = 2;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int N      = 1 << LANE_W;
  localparam int D      = 1 << ADDR_W;

  bit                      clock = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic                    sol_start;
  logic [N-1:0]            sol_valid = '0;
  logic [N*DATA_W-1:0]     sol_data = '0;
  logic [N-1:0]            sol_done = '0;
  logic [N-1:0]            sol_continue;
  logic                    rd_en = 1'b0;
  logic [ADDR_W+LANE_W-1:0] rd_pixel = '0;
  logic                    rd_valid;
  logic [DATA_W-1:0]       rd_data;
  logic                    busy;
  logic                    done;
  logic                    frame_ready;
  logic [N-1:0]            overflow;

  multi_solver_pingpong #(.LANE_W(LANE_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .start(start), .sol_start(sol_start),
    .sol_valid(sol_valid), .sol_data(sol_data), .sol_done(sol_done),
    .sol_continue(sol_continue), .rd_en(rd_en), .rd_pixel(rd_pixel),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy), .done(done),
    .frame_ready(frame_ready), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;
  int n_sst = 0;
  int n_done = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: frame-level behaviour, memory held as [bank][lane][slot].
  bit          m_init = 1'b0;
  bit          m_busy, m_rdbank, m_sst, m_done, m_fr, m_rv;
  int          m_ptr [N];
  bit [N-1:0]  m_ovf, m_acc;
  logic [7:0]  m_rd;
  bit          m_rd_known;
  logic [7:0]  m_mem   [2][N][D];
  bit          m_known [2][N][D];

  always @(posedge clock) begin
    if (reset) begin
      m_init = 1'b1; m_busy = 0; m_rdbank = 1; m_sst = 0; m_done = 0; m_fr = 0;
      m_rv = 0; m_ovf = '0; m_acc = '0; m_rd = 8'h00; m_rd_known = 1;
      for (int i = 0; i < N; i++) m_ptr[i] = 0;
    end else begin
      m_sst = 0; m_done = 0; m_acc = '0;
      m_rv = rd_en;
      if (rd_en) begin
        int lane, slot;
        lane = int'(rd_pixel) % N;
        slot = int'(rd_pixel) / N;
        m_rd       = m_mem[m_rdbank][lane][slot];
        m_rd_known = m_known[m_rdbank][lane][slot];
      end
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_sst = 1; m_ovf = '0;
          for (int i = 0; i < N; i++) m_ptr[i] = 0;
        end
      end else begin
        int wb;
        wb = m_rdbank ? 0 : 1;
        for (int i = 0; i < N; i++) begin
          if (sol_valid[i] && !sol_done[i]) begin
            m_acc[i] = 1;
            if (m_ptr[i] < D) begin
              m_mem[wb][i][m_ptr[i]]   = sol_data[i*DATA_W +: DATA_W];
              m_known[wb][i][m_ptr[i]] = 1;
              m_ptr[i]++;
            end else begin
              m_ovf[i] = 1;
            end
          end
        end
        if (&sol_done) begin
          m_busy = 0; m_rdbank = ~m_rdbank; m_done = 1; m_fr = 1;
        end
      end
    end
  end

  // Compare process: every cycle, away from the clock edge.
  always @(negedge clock) begin
    if (m_init) begin
      n_sst  += int'(sol_start);
      n_done += int'(done);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("sol_start", 32'(sol_start), 32'(m_sst));
      chk("done", 32'(done), 32'(m_done));
      chk("frame_ready", 32'(frame_ready), 32'(m_fr));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("sol_continue", 32'(sol_continue), m_busy ? 32'(sol_valid & ~sol_done) : 32'd0);
      chk("rd_valid", 32'(rd_valid), 32'(m_rv));
      if (m_rd_known) chk("rd_data", 32'(rd_data), 32'(m_rd));
    end
  end

  int tgt [N];
  bit dmode;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic rand_rd();
    rd_en    = 1'($urandom_range(0, 1));
    rd_pixel = (ADDR_W+LANE_W)'($urandom_range(0, N*D-1));
  endtask

  // One frame: lanes emit tgt[i] accepted results, then hold sol_done until completion.
  task automatic run_frame(input bit hit_start);
    int em [N];
    int budget;
    bit fin;
    int s0, d0;
    s0 = n_sst; d0 = n_done;
    for (int i = 0; i < N; i++) em[i] = 0;
    sol_valid = '0; sol_done = '0; start = 1; rand_rd();
    tick();
    start = 0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_pulse", 32'(sol_start), 32'd1);
    chk("start_ovf_clear", 32'(overflow), 32'd0);
    fin = 0; budget = 0;
    while (!fin && budget < 300) begin
      for (int i = 0; i < N; i++) if (m_acc[i] && em[i] < tgt[i]) em[i]++;
      if (m_done) begin
        fin = 1;
      end else begin
        for (int i = 0; i < N; i++) begin
          if (em[i] < tgt[i]) begin
            sol_done[i]  = 0;
            sol_valid[i] = ($urandom_range(0, 3) != 0);
            sol_data[i*DATA_W +: DATA_W] = dmode ? 8'($urandom) : 8'(16*i + em[i]);
          end else begin
            sol_done[i]  = 1;
            sol_valid[i] = 1'($urandom_range(0, 1));
            sol_data[i*DATA_W +: DATA_W] = 8'($urandom);
          end
        end
        start = hit_start && (($urandom_range(0, 7) == 0) || (&sol_done));
        rand_rd();
        tick();
        budget++;
      end
    end
    if (!fin) begin
      n_err++;
      $display("FAIL frame_timeout: got no done after %0d cycles, required done", budget);
    end
    start = 0; sol_done = '0; sol_valid = 4'($urandom); rd_en = 0;
    tick();
    chk("one_sol_start", 32'(n_sst - s0), 32'd1);
    chk("one_done", 32'(n_done - d0), 32'd1);
    chk("idle_after_frame", 32'(busy), 32'd0);
    chk("frame_ready_set", 32'(frame_ready), 32'd1);
    sol_valid = '0;
  endtask

  task automatic read_pix(input int p, input logic [7:0] exp, input string nm);
    rd_en = 1; rd_pixel = (ADDR_W+LANE_W)'(p);
    tick();
    rd_en = 0;
    chk(nm, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int cnt, budget;
    reset = 1;
    tick(); tick();
    reset = 0;
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_ready", 32'(frame_ready), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);

    // Idle: valids and dones wiggle, nothing may be acknowledged.
    for (int c = 0; c < 6; c++) begin
      sol_valid = 4'($urandom); sol_done = 4'($urandom); rand_rd();
      tick();
    end
    sol_valid = '0; sol_done = '0;

    // Basic frame: lane i emits 16*i+j.
    dmode = 0;
    for (int i = 0; i < N; i++) tgt[i] = D;
    run_frame(0);
    for (int p = 0; p < N*D; p++) read_pix(p, 8'(16*(p%4) + p/4), "basic_pixel");
    read_pix(6, 8'd33, "basic_pixel6");

    // Ping-pong with random data, reads and start pulses during RUN.
    dmode = 1;
    for (int i = 0; i < N; i++) tgt[i] = $urandom_range(1, D);
    run_frame(1);

    // Overflow: lane 1 emits 6 results into a 4-deep bank.
    dmode = 0;
    tgt[0] = 2; tgt[1] = 6; tgt[2] = 3; tgt[3] = 1;
    run_frame(1);
    chk("overflow_lane1", 32'(overflow), 32'h2);
    for (int k = 0; k < D; k++) read_pix(1 + 4*k, 8'(16 + k), "ovf_lane1_slot");
    for (int c = 0; c < 4; c++) begin rand_rd(); tick(); end
    chk("overflow_sticky", 32'(overflow), 32'h2);

    // Random frames; the start check inside clears the overflow flag.
    for (int f = 0; f < 5; f++) begin
      dmode = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) tgt[i] = $urandom_range(0, D + 2);
      run_frame(1'($urandom_range(0, 1)));
      for (int c = 0; c < 8; c++) begin rand_rd(); sol_valid = 4'($urandom); tick(); end
      sol_valid = '0;
    end

    // Reset mid-frame after two accepted writes on lane 0.
    start = 1; tick(); start = 0;
    cnt = 0; budget = 0;
    while (cnt < 2 && budget < 20) begin
      sol_valid = 4'b0001; sol_data[7:0] = 8'(8'hA0 + cnt);
      tick();
      if (m_acc[0]) cnt++;
      budget++;
    end
    if (cnt < 2) begin
      n_err++;
      $display("FAIL midframe_writes: got %0d accepted, required 2", cnt);
    end
    sol_valid = '0; reset = 1;
    tick();
    reset = 0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_frame_ready", 32'(frame_ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_rd_data", 32'(rd_data), 32'd0);
    tick();
    dmode = 0;
    for (int i = 0; i < N; i++) tgt[i] = D;
    run_frame(0);
    read_pix(6, 8'd33, "fresh_frame_pixel6");
    read_pix(0, 8'd0, "fresh_frame_pixel0");
    read_pix(15, 8'd51, "fresh_frame_pixel15");

    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
